// File: rtl/led_disp_pkg.sv
// Shared definitions for the LED display arbiter slice.
// Contents:
//   state_t   - arbiter FSM states (IDLE, HOLD)
//   NREQ_DEF  - default number of requesters
//   N_DEF     - default displayed value width
//   circ_inc  - circular index increment, wraps to 0 at n
package led_disp_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam int NREQ_DEF = 4;
  localparam int N_DEF    = 8;

  function automatic int circ_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/led_display_arbiter_rr_picker.sv
// Combinational round-robin picker.
// Finds the first set bit of req at or after rr_ptr, searching circularly.
// Ports:
//   req    - request vector
//   rr_ptr - index where the search starts
//   any    - high when at least one request is set
//   idx    - index of the chosen request (0 when any is low)
module rr_picker
  import led_disp_pkg::*;
#(
  parameter  int NREQ = NREQ_DEF,
  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] rr_ptr,
  output logic            any,
  output logic [IDXW-1:0] idx
);

  // Walk offsets from farthest to nearest so the nearest set bit wins.
  always_comb begin
    int pos;
    any = |req;
    idx = '0;
    pos = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      pos = int'(rr_ptr) + k;
      if (pos >= NREQ) pos = pos - NREQ;
      if (req[pos]) idx = IDXW'(pos);
    end
  end

endmodule

// File: rtl/led_display_arbiter.sv
// Round-robin arbiter sharing one seven-segment display between NREQ
// requesters. A winner's value is captured and shown for HOLD_CYCLES
// cycles, after which the winner gets a one-cycle done pulse.
// Ports:
//   clk        - system clock, rising edge
//   reset      - synchronous active-high reset
//   req        - per-requester request level
//   req_value  - packed values, requester i at [i*N +: N]
//   grant      - one-hot owner of the display (or zero)
//   done       - one-cycle pulse to the owner when its hold completes
//   disp_value - value driven to the display driver
//   disp_valid - high while a grant is active
module led_display_arbiter
  import led_disp_pkg::*;
#(
  parameter int NREQ        = NREQ_DEF,
  parameter int N           = N_DEF,
  parameter int HOLD_CYCLES = 1024,
  parameter int CNT_W       = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*N-1:0] req_value,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   done,
  output logic [N-1:0]      disp_value,
  output logic              disp_valid
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  hold_cnt, hold_cnt_nxt;
  logic [IDXW-1:0]   rr_ptr, rr_ptr_nxt;
  logic [IDXW-1:0]   owner, owner_nxt;
  logic [NREQ-1:0]   grant_nxt, done_nxt;
  logic [N-1:0]      disp_value_nxt;
  logic              disp_valid_nxt;
  logic              pick_any;
  logic [IDXW-1:0]   pick_idx;

  rr_picker #(.NREQ(NREQ)) u_picker (
    .req    (req),
    .rr_ptr (rr_ptr),
    .any    (pick_any),
    .idx    (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      hold_cnt   <= '0;
      rr_ptr     <= '0;
      owner      <= '0;
      grant      <= '0;
      done       <= '0;
      disp_value <= '0;
      disp_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      hold_cnt   <= hold_cnt_nxt;
      rr_ptr     <= rr_ptr_nxt;
      owner      <= owner_nxt;
      grant      <= grant_nxt;
      done       <= done_nxt;
      disp_value <= disp_value_nxt;
      disp_valid <= disp_valid_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    hold_cnt_nxt   = hold_cnt;
    rr_ptr_nxt     = rr_ptr;
    owner_nxt      = owner;
    grant_nxt      = grant;
    done_nxt       = '0;
    disp_value_nxt = disp_value;
    disp_valid_nxt = disp_valid;

    case (state)
      IDLE: begin
        if (pick_any) begin
          owner_nxt            = pick_idx;
          grant_nxt            = '0;
          grant_nxt[pick_idx]  = 1'b1;
          disp_value_nxt       = req_value[pick_idx*N +: N];
          disp_valid_nxt       = 1'b1;
          hold_cnt_nxt         = '0;
          state_nxt            = HOLD;
        end
      end

      HOLD: begin
        // Abandon is checked first so it wins over a coincident expiry.
        if (!req[owner] || hold_cnt == CNT_W'(HOLD_CYCLES - 1)) begin
          if (req[owner]) done_nxt[owner] = 1'b1;
          grant_nxt      = '0;
          disp_valid_nxt = 1'b0;
          rr_ptr_nxt     = IDXW'(circ_inc(int'(owner), NREQ));
          state_nxt      = IDLE;
        end else begin
          hold_cnt_nxt = hold_cnt + CNT_W'(1);
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: doc/led_display_arbiter.md
Name: led_display_arbiter

Overview:
- Shares the single two-digit seven-segment display (DigitLEDdriver) between NREQ requesters.
- Each requester presents an 8-bit value and raises a request. The arbiter grants one requester at a time, round-robin.
- The granted value is captured and driven to the display driver's value input for a fixed hold time. The winner then gets a done pulse.
- Sits between application blocks (counters, status sources) and DigitLEDdriver. The handshake is one-hot grant/done.

Parameters:
- NREQ, 4, number of requesters (2..8)
- N, 8, width of the displayed value (matches DigitLEDdriver N)
- HOLD_CYCLES, 1024, clk cycles a granted value is displayed (>= 2)
- CNT_W, 10, hold counter width; must satisfy 2**CNT_W >= HOLD_CYCLES

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- req  input  NREQ  per-requester request level; held high until done or abandon
- req_value  input  NREQ*N  packed values; requester i occupies bits [i*N+N-1 : i*N]
- grant  output  NREQ  one-hot (or zero) current owner of the display
- done  output  NREQ  one-cycle pulse to the owner when its hold time completes
- disp_value  output  N  value to DigitLEDdriver value input
- disp_valid  output  1  high while a grant is active

Behaviour:
- All outputs are registered.
- Reset (synchronous, sampled at rising edge):
  - grant=0, done=0, disp_value=0, disp_valid=0
  - rr_ptr=0, hold_cnt=0, state=IDLE
- Reset mid-HOLD: same as above; no done pulse is issued; the captured value is lost.
- States: IDLE, HOLD.
- IDLE:
  - When req != 0 at an edge, pick the first index j with req[j]=1, searching circularly from rr_ptr upward.
  - Same edge: grant=one-hot(j), disp_value=req_value slice j, disp_valid=1, hold_cnt=0, state=HOLD.
  - Latency: req high before edge k gives grant visible after edge k.
  - When req == 0: stay in IDLE, outputs hold. disp_value keeps its last value.
- HOLD:
  - hold_cnt increments by 1 each cycle.
  - disp_value is frozen; changes on req_value are ignored.
  - Normal expiry: at the edge where hold_cnt == HOLD_CYCLES-1:
    - done[j]=1 for exactly one cycle; grant=0; disp_valid=0
    - rr_ptr=(j+1) mod NREQ; state=IDLE
  - The display is therefore owned for exactly HOLD_CYCLES cycles.
  - Abandon: req[j] sampled low during HOLD, before expiry:
    - next edge: grant=0, disp_valid=0, no done pulse
    - rr_ptr=(j+1) mod NREQ; state=IDLE
  - Simultaneous abandon and expiry on the same edge: abandon wins, no done.
- Back-to-back grants:
  - IDLE always lasts at least one cycle with grant=0 between grants.
  - A requester that keeps req high after done re-competes. Fairness comes from rr_ptr advancing past it.
- Requests from other indices during HOLD are not latched; they are sampled again in IDLE.
- done[i] is only ever asserted for an i that was granted the previous cycle. grant and done are never high together.
- disp_value keeps its last value after release, so the display shows the last value rather than blanking.
- hold_cnt never wraps; it saturates conceptually because HOLD leaves at HOLD_CYCLES-1.

Decomposition:
- Shared package led_disp_pkg holds:
  - state enum {IDLE, HOLD}
  - default constants NREQ_DEF=4, N_DEF=8
  - a function for the circular-index increment
- One sub-module, rr_picker. It is combinational:
  - inputs: req, rr_ptr
  - outputs: any, idx (clog2(NREQ) bits)
  - function: first set bit at or after rr_ptr, circularly
- The arbiter instantiates rr_picker and owns the state register, hold counter and output registers.

Test Plan (NREQ=4, N=8, HOLD_CYCLES=4):
- Reset: assert reset 2 cycles with req=4'b1111 -> grant=0, done=0, disp_value=0x00, disp_valid=0. The first grant after release is grant=4'b0001.
- Single requester: req=4'b0100, value2=0xA5 -> grant=4'b0100 one cycle later. disp_value=0xA5 for 4 cycles. done=4'b0100 one cycle. Then grant=0 and disp_value stays 0xA5.
- Round-robin: req=4'b1111 held with values 0x10,0x21,0x32,0x43 -> grants in order 0001,0010,0100,1000,0001. Each lasts 4 cycles, separated by exactly one idle cycle.
- Abandon: req=4'b0010 granted, drop req[1] after 2 cycles -> grant=0 next edge, no done. rr_ptr=2, so with req=4'b0011 the next grant goes to 4'b0001.
- Value freeze: change value0 from 0x11 to 0x99 during the hold -> disp_value stays 0x11 until release.
- Reset mid-hold: assert reset when hold_cnt=2 -> grant=0, disp_value=0x00, no done pulse. rr_ptr=0, so with req=4'b1111 the first post-reset grant is 4'b0001.
